// File: rtl/hart_scoreboard.sv
// Per-hart register scoreboard: counts in-flight register writes from issue to
// writeback/kill and flags stalls for ID-stage source/destination hazards.
module hart_scoreboard #(
  parameter int unsigned NHARTS = 4,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned HW     = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [HW-1:0]     issue_hart,
  input  logic [4:0]        issue_rd,
  input  logic              wb_valid,
  input  logic [HW-1:0]     wb_hart,
  input  logic [4:0]        wb_rd,
  input  logic              kill_valid,
  input  logic [HW-1:0]     kill_hart,
  input  logic [4:0]        kill_rd,
  input  logic              q_valid,
  input  logic [HW-1:0]     q_hart,
  input  logic [4:0]        q_rs1,
  input  logic [4:0]        q_rs2,
  input  logic [4:0]        q_rd,
  input  logic              q_regwrite,
  input  logic              q_bypass1,
  input  logic              q_bypass2,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              stall,
  output logic [NHARTS-1:0] pend_any,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam int MAXI = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q [NHARTS][NREGS];
  logic [CNT_W-1:0] cnt_d [NHARTS][NREGS];
  logic             uf_c;
  logic             rd_full_c;
  int               sum;

  // Next counter values: all same-cycle deltas on one counter are summed, then clamped
  always_comb begin
    uf_c = 1'b0;
    sum  = 0;
    for (int h = 0; h < int'(NHARTS); h++) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        sum = int'(cnt_q[h][r]);
        if (issue_valid && issue_regwrite && issue_hart == HW'(h) && issue_rd == 5'(r))
          sum = sum + 1;
        if (wb_valid && wb_hart == HW'(h) && wb_rd == 5'(r))
          sum = sum - 1;
        if (kill_valid && kill_hart == HW'(h) && kill_rd == 5'(r))
          sum = sum - 1;
        if (r == 0) begin
          cnt_d[h][r] = '0;
        end else if (sum < 0) begin
          cnt_d[h][r] = '0;
          uf_c        = 1'b1;
        end else if (sum > MAXI) begin
          cnt_d[h][r] = MAXV;
        end else begin
          cnt_d[h][r] = CNT_W'(sum);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int h = 0; h < int'(NHARTS); h++)
        for (int r = 0; r < int'(NREGS); r++)
          cnt_q[h][r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_underflow <= err_underflow | uf_c;
    end
  end

  // Query path sees registered state only; same-cycle updates appear next cycle
  always_comb begin
    busy_rs1  = q_valid && (q_rs1 != 5'd0) && (cnt_q[q_hart][q_rs1] != '0);
    busy_rs2  = q_valid && (q_rs2 != 5'd0) && (cnt_q[q_hart][q_rs2] != '0);
    rd_full_c = q_regwrite && (q_rd != 5'd0) && (cnt_q[q_hart][q_rd] == MAXV);
    stall     = q_valid && ((busy_rs1 && !q_bypass1) || (busy_rs2 && !q_bypass2) || rd_full_c);
  end

  always_comb begin
    pend_any = '0;
    for (int h = 0; h < int'(NHARTS); h++)
      for (int r = 1; r < int'(NREGS); r++)
        if (cnt_q[h][r] != '0)
          pend_any[h] = 1'b1;
  end

endmodule

// File: doc/hart_scoreboard.md
Name: hart_scoreboard

Overview:
Per-hart register scoreboard for the multithreaded RISC-V pipeline. It is the producer-side complement to the operand forwarding logic. It records every register write issued from ID into EX, tagged by hart ID, and retires the record when that write reaches WB. The ID stage queries it for rs1/rs2 of the decoding instruction and gets a stall when a same-hart write is still outstanding and cannot be bypassed.

Parameters:
NHARTS, 4, number of hardware threads; hart ID width HW = clog2(NHARTS)
NREGS, 32, architectural registers per hart
CNT_W, 2, width of the per-register in-flight write counter

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
issue_valid  in  1  instruction leaving ID into EX this cycle
issue_regwrite  in  1  issuing instruction writes rd
issue_hart  in  HW  hart ID of issuing instruction
issue_rd  in  5  destination register of issuing instruction
wb_valid  in  1  register-file write this cycle
wb_hart  in  HW  hart ID of writeback
wb_rd  in  5  destination register of writeback
kill_valid  in  1  issued instruction squashed before WB (branch flush in EX/Mem)
kill_hart  in  HW  hart ID of killed instruction
kill_rd  in  5  rd of killed instruction (only sent if it had regwrite)
q_valid  in  1  ID-stage query active
q_hart  in  HW  hart ID of instruction in ID
q_rs1  in  5  source register 1
q_rs2  in  5  source register 2
q_rd  in  5  destination of instruction in ID
q_regwrite  in  1  instruction in ID writes rd
q_bypass1  in  1  forwarding network can supply rs1 this cycle
q_bypass2  in  1  forwarding network can supply rs2 this cycle
busy_rs1  out  1  rs1 has outstanding same-hart write
busy_rs2  out  1  rs2 has outstanding same-hart write
stall  out  1  hold instruction in ID
pend_any  out  NHARTS  bit h = hart h has any outstanding write
err_underflow  out  1  sticky: retire seen with counter already 0

Behaviour:
- State: NHARTS x NREGS counters of CNT_W bits. Register 0 is never tracked and always reads 0.
- Reset (rst_n low at clk edge): all counters 0, err_underflow 0. As a result busy_rs1, busy_rs2, stall and pend_any are all 0 in the cycle after reset. Reset mid-operation discards all in-flight records without error.
- Increment: issue_valid & issue_regwrite & issue_rd != 0 adds +1 to counter[issue_hart][issue_rd].
- Decrement: wb_valid & wb_rd != 0 adds -1 to counter[wb_hart][wb_rd]. kill_valid & kill_rd != 0 adds -1 to counter[kill_hart][kill_rd].
- Simultaneous events on the same counter sum as signed deltas in one update. Examples: issue+wb gives net 0; wb+kill gives -2.
- Underflow: if the summed decrement would take a counter below 0, it saturates at 0 and err_underflow sets. err_underflow clears only on reset.
- Overflow: issue is never accepted into a full counter. stall prevents it (see below). An increment into a counter at 2^CNT_W-1 anyway saturates and is not flagged.
- Query (combinational, from registered state only): busy_rs1 = q_valid & q_rs1 != 0 & counter[q_hart][q_rs1] != 0. busy_rs2 is formed the same way.
- Same-cycle wb/kill does NOT clear busy for the query. Same-cycle issue does NOT set it. Updates become visible the next cycle.
- Hart isolation: counters of other harts never affect a query.
- stall = q_valid & ((busy_rs1 & !q_bypass1) | (busy_rs2 & !q_bypass2) | (q_regwrite & q_rd != 0 & counter[q_hart][q_rd] == max)).
- pend_any[h] = OR of all counters of hart h != 0, from registered state. Used by fence and context-switch logic.
- Latency: all state updates take effect 1 cycle after the qualifying edge. There is no other pipelining.

Test Plan:
- Reset with arbitrary counters loaded, rst_n low one cycle -> next cycle pend_any=0000, busy/stall 0, err_underflow 0.
- Issue hart1 x5 at cycle 0. Query hart1 rs1=x5, bypass1=0 at cycle 1 -> busy_rs1=1, stall=1. Same query with hart2 -> busy_rs1=0, stall=0. wb hart1 x5 at cycle 3 -> busy_rs1=0 from cycle 4, pend_any[1]=0.
- Issue hart0 x7 twice, one wb -> counter 1, busy stays 1. Second wb -> busy 0. Issue+wb of hart0 x7 in the same cycle with counter 1 -> counter remains 1.
- Issue hart3 x0 and query rs2=x0 -> never busy, pend_any[3]=0.
- wb hart2 x9 with counter 0 -> counter stays 0, err_underflow=1 and stays high until reset. Kill hart2 x9 after one issue -> counter 0, no error.
- Counter hart0 x4 at 3, ID instruction hart0 regwrite rd=x4 -> stall=1. Query rs1=x4 with q_bypass1=1 and no rd conflict -> busy_rs1=1, stall=0.
